// File: rtl/ingress_parser.sv
// ingress_parser: per-port header decode, framing and length checking, and
// one-cycle registered forwarding of good packets into the shared-buffer switch.
module ingress_parser #(
  parameter int data_width     = 64,
  parameter int num_of_ports   = 16,
  parameter int des_port_width = 7,
  parameter int priority_width = 3,
  parameter int max_pkt_bytes  = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic                      in_vld,
  input  logic [data_width-1:0]     in_data,
  input  logic                      almost_full,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_vld,
  output logic [data_width-1:0]     out_data,
  output logic [des_port_width-1:0] out_des,
  output logic [priority_width-1:0] out_prio,
  output logic                      out_err,
  output logic                      err_frame,
  output logic                      err_len,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int                        LEN_LSB     = des_port_width + priority_width;
  localparam logic [des_port_width-1:0] NUM_PORTS_C = des_port_width'(num_of_ports);
  localparam logic [10:0]               MAX_LEN_C   = 11'(max_pkt_bytes);
  localparam logic [15:0]               CNT_MAX_C   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [11:0]               r_rem;
  logic [11:0]               w_rem_nxt;
  logic [11:0]               w_pb;
  logic [des_port_width-1:0] w_des;
  logic [priority_width-1:0] w_prio;
  logic [10:0]               w_len;
  logic                      w_hdr_legal;
  logic                      w_vld;
  logic                      w_sop;
  logic                      w_eop;
  logic                      w_err;
  logic                      w_frame;
  logic                      w_len_err;
  logic                      w_load_hdr;
  logic                      w_pkt_inc;
  logic                      w_drop_inc;
  logic [data_width-1:0]     w_data;

  assign w_des       = in_data[des_port_width-1:0];
  assign w_prio      = in_data[des_port_width +: priority_width];
  assign w_len       = in_data[LEN_LSB +: 11];
  assign w_pb        = ({1'b0, w_len} + 12'd7) >> 3'd3;
  assign w_hdr_legal = (w_des < NUM_PORTS_C) && (w_len != 11'd0) &&
                       (w_len <= MAX_LEN_C) && !almost_full;

  // Next-state, remaining-beat and output-beat decisions for the current input beat.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_vld       = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_err       = 1'b0;
    w_frame     = 1'b0;
    w_len_err   = 1'b0;
    w_load_hdr  = 1'b0;
    w_pkt_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    w_data      = '0;
    case (r_state)
      ST_IDLE, ST_DROP: begin
        if (in_vld && in_sop) begin
          // A header seen while discarding is a resync point, flagged as a framing error.
          w_frame = (r_state == ST_DROP);
          if (w_hdr_legal) begin
            w_vld      = 1'b1;
            w_sop      = 1'b1;
            w_data     = in_data;
            w_load_hdr = 1'b1;
            w_pkt_inc  = 1'b1;
            w_rem_nxt  = w_pb;
            if (in_eop) begin
              w_eop       = 1'b1;
              w_err       = 1'b1;
              w_len_err   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_FWD;
            end
          end else begin
            w_drop_inc  = 1'b1;
            w_state_nxt = in_eop ? ST_IDLE : ST_DROP;
          end
        end else if (in_vld) begin
          if (r_state == ST_IDLE) begin
            w_frame = 1'b1;
          end else if (in_eop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_FWD: begin
        if (in_vld && in_sop) begin
          w_vld       = 1'b1;
          w_eop       = 1'b1;
          w_err       = 1'b1;
          w_frame     = 1'b1;
          w_drop_inc  = 1'b1;
          w_state_nxt = in_eop ? ST_IDLE : ST_DROP;
        end else if (in_vld) begin
          w_vld  = 1'b1;
          w_data = in_data;
          if (r_rem == 12'd1) begin
            w_eop = 1'b1;
            if (in_eop) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_err       = 1'b1;
              w_len_err   = 1'b1;
              w_state_nxt = ST_DROP;
            end
          end else if (in_eop) begin
            w_eop       = 1'b1;
            w_err       = 1'b1;
            w_len_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_rem_nxt = r_rem - 12'd1;
          end
        end else begin
          w_state_nxt = ST_FWD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = 12'd0;
      end
    endcase
  end

  // State, registered outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rem     <= 12'd0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_vld   <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
      out_des   <= '0;
      out_prio  <= '0;
      err_frame <= 1'b0;
      err_len   <= 1'b0;
      pkt_cnt   <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      out_sop   <= w_sop;
      out_eop   <= w_eop;
      out_vld   <= w_vld;
      out_err   <= w_err;
      out_data  <= w_data;
      err_frame <= w_frame;
      err_len   <= w_len_err;
      if (w_load_hdr) begin
        out_des  <= w_des;
        out_prio <= w_prio;
      end
      if (w_pkt_inc && (pkt_cnt != CNT_MAX_C)) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (w_drop_inc && (drop_cnt != CNT_MAX_C)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ingress_parser.sv
// Randomized and directed self-checking bench for ingress_parser against a
// beat-level reference model that tracks "beats still owed" per packet.
module tb_ingress_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_sop, in_eop, in_vld, almost_full;
  logic [63:0] in_data;
  logic        out_sop, out_eop, out_vld, out_err, err_frame, err_len;
  logic [63:0] out_data;
  logic [6:0]  out_des;
  logic [2:0]  out_prio;
  logic [15:0] pkt_cnt, drop_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model: packet-level bookkeeping
  bit          m_in_pkt, m_skip;
  int          m_left;
  logic [6:0]  m_des;
  logic [2:0]  m_prio;
  logic [15:0] m_pkt, m_drop;
  logic        e_vld, e_sop, e_eop, e_err, e_frame, e_lenerr;
  logic [63:0] e_data;

  ingress_parser dut (
    .clk(clk), .rst_n(rst_n), .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld),
    .in_data(in_data), .almost_full(almost_full), .out_sop(out_sop), .out_eop(out_eop),
    .out_vld(out_vld), .out_data(out_data), .out_des(out_des), .out_prio(out_prio),
    .out_err(out_err), .err_frame(err_frame), .err_len(err_len),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_hdr(input int des, input int prio, input int len);
    logic [63:0] d;
    d        = {$urandom, $urandom};
    d[6:0]   = des[6:0];
    d[9:7]   = prio[2:0];
    d[20:10] = len[10:0];
    return d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_in_pkt = 0; m_skip = 0; m_left = 0; m_des = '0; m_prio = '0;
    m_pkt = '0; m_drop = '0;
    {e_vld, e_sop, e_eop, e_err, e_frame, e_lenerr} = '0;
    e_data = '0;
  endtask

  task automatic model_beat();
    int des, len;
    bit ok;
    {e_vld, e_sop, e_eop, e_err, e_frame, e_lenerr} = '0;
    e_data = '0;
    des = int'(in_data[6:0]);
    len = int'(in_data[20:10]);
    ok  = (des < 16) && (len >= 1) && (len <= 1024) && !almost_full;
    if (!in_vld) return;
    if (m_in_pkt) begin
      if (in_sop) begin
        e_vld = 1; e_eop = 1; e_err = 1; e_frame = 1;
        m_drop = sat_inc(m_drop);
        m_in_pkt = 0; m_skip = !in_eop;
      end else begin
        e_vld = 1; e_data = in_data;
        m_left = m_left - 1;
        if (m_left == 0 || in_eop) begin
          e_eop = 1;
          e_err = !(in_eop && m_left == 0);
          e_lenerr = e_err;
          m_in_pkt = 0; m_skip = !in_eop;
        end
      end
    end else if (in_sop) begin
      e_frame = m_skip;
      if (ok) begin
        e_vld = 1; e_sop = 1; e_data = in_data;
        m_des = in_data[6:0]; m_prio = in_data[9:7];
        m_pkt = sat_inc(m_pkt);
        m_skip = 0;
        if (in_eop) begin
          e_eop = 1; e_err = 1; e_lenerr = 1;
        end else begin
          m_in_pkt = 1; m_left = (len + 7) / 8;
        end
      end else begin
        m_drop = sat_inc(m_drop);
        m_skip = !in_eop;
      end
    end else if (m_skip) begin
      if (in_eop) m_skip = 0;
    end else begin
      e_frame = 1;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [63:0] d, input logic af);
    in_vld = v; in_sop = s; in_eop = e; in_data = d; almost_full = af;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_beat();
    #1;
  endtask

  function automatic logic [111:0] act_vec();
    return {out_vld, out_sop, out_eop, (e_vld && e_eop) ? out_err : 1'b0, err_frame, err_len,
            pkt_cnt, drop_cnt, e_vld ? out_data : 64'd0, e_vld ? out_des : 7'd0,
            e_vld ? out_prio : 3'd0};
  endfunction

  function automatic logic [111:0] exp_vec();
    return {e_vld, e_sop, e_eop, (e_vld && e_eop) ? e_err : 1'b0, e_frame, e_lenerr,
            m_pkt, m_drop, e_vld ? e_data : 64'd0, e_vld ? m_des : 7'd0, e_vld ? m_prio : 3'd0};
  endfunction

  function automatic logic [111:0] raw_outs();
    return {out_vld, out_sop, out_eop, out_err, err_frame, err_len, pkt_cnt, drop_cnt,
            out_data, out_des, out_prio};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, (i == 0), 1'b0, mk_hdr(3, 5, 20), 1'b0);
      checks++;
      if (raw_outs() !== 112'd0) begin
        failures++;
        $display("FAIL reset cyc%0d act=%h exp=0", i, raw_outs());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_legal();
    logic [63:0] beats [4];
    beats[0] = mk_hdr(3, 5, 20);
    for (int i = 1; i < 4; i++) beats[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        step(1'b0, 1'b1, 1'b1, 64'd0, 1'b0);
        checks++;
        if (act_vec() !== exp_vec()) begin
          failures++; $display("FAIL legal gap%0d act=%h exp=%h", i, act_vec(), exp_vec());
        end
      end
      step(1'b1, (i == 0), (i == 3), beats[i], 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL legal beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if (out_vld !== 1'b1 || out_data !== beats[i] || out_sop !== (i == 0) || out_eop !== (i == 3)) begin
        failures++;
        $display("FAIL legal_frame beat%0d vld=%b sop=%b eop=%b data=%h want data=%h", i, out_vld, out_sop, out_eop, out_data, beats[i]);
      end
      checks++;
      if (out_des !== 7'd3 || out_prio !== 3'd5) begin
        failures++; $display("FAIL legal_hdr beat%0d des=%0d prio=%0d want 3/5", i, out_des, out_prio);
      end
    end
    checks++;
    if (out_err !== 1'b0 || pkt_cnt !== 16'd1) begin
      failures++; $display("FAIL legal_end err=%b pkt_cnt=%0d want 0/1", out_err, pkt_cnt);
    end
  endtask

  task automatic test_early_eop();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 0), (i == 2), (i == 0) ? mk_hdr(1, 2, 24) : {$urandom, $urandom}, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL early beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (out_eop !== 1'b1 || out_err !== 1'b1 || err_len !== 1'b1) begin
      failures++; $display("FAIL early_eop eop=%b err=%b err_len=%b want 1/1/1", out_eop, out_err, err_len);
    end
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    checks++;
    if (err_len !== 1'b0 || out_vld !== 1'b0) begin
      failures++; $display("FAIL early_pulse err_len=%b vld=%b want 0/0", err_len, out_vld);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, (i == 0), (i == 1), (i == 0) ? mk_hdr(2, 1, 1) : {$urandom, $urandom}, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL early_next beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (out_eop !== 1'b1 || out_err !== 1'b0 || err_len !== 1'b0) begin
      failures++; $display("FAIL early_next_end eop=%b err=%b err_len=%b want 1/0/0", out_eop, out_err, err_len);
    end
  endtask

  task automatic test_long();
    int nvld = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), (i == 3), (i == 0) ? mk_hdr(4, 0, 8) : {$urandom, $urandom}, 1'b0);
      if (out_vld === 1'b1) nvld++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL long beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (out_eop !== 1'b1 || out_err !== 1'b1 || err_len !== 1'b1) begin
          failures++; $display("FAIL long_cut eop=%b err=%b err_len=%b want 1/1/1", out_eop, out_err, err_len);
        end
      end
    end
    checks++;
    if (nvld != 2) begin
      failures++; $display("FAIL long_count out_beats=%0d want 2", nvld);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 0), (i == 2), (i == 0) ? mk_hdr(5, 7, 16) : {$urandom, $urandom}, 1'b0);
      checks++;
      if (act_vec() !== exp_vec() || out_vld !== 1'b1) begin
        failures++; $display("FAIL long_next beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] d0;
    bit seen = 0;
    d0 = drop_cnt;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 2; i++) begin
        step(1'b1, (i == 0), (i == 1),
             (i == 1) ? {$urandom, $urandom} : (p == 0) ? mk_hdr(16, 0, 8) : (p == 1) ? mk_hdr(1, 0, 0) : mk_hdr(1, 0, 1025),
             1'b0);
        if (out_vld !== 1'b0 || err_frame !== 1'b0 || err_len !== 1'b0) seen = 1;
        checks++;
        if (act_vec() !== exp_vec()) begin
          failures++; $display("FAIL illegal p%0d beat%0d act=%h exp=%h", p, i, act_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (seen || drop_cnt !== d0 + 16'd3) begin
      failures++; $display("FAIL illegal_sum activity=%0d drop_cnt=%0d want 0/%0d", seen, drop_cnt, d0 + 16'd3);
    end
  endtask

  task automatic test_almost_full();
    logic [15:0] d0;
    int nvld = 0;
    d0 = drop_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 0), (i == 2), (i == 0) ? mk_hdr(6, 3, 16) : {$urandom, $urandom}, (i == 0));
      if (out_vld === 1'b1) nvld++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL af_hdr beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (nvld != 0 || drop_cnt !== d0 + 16'd1) begin
      failures++; $display("FAIL af_drop beats=%0d drop_cnt=%0d want 0/%0d", nvld, drop_cnt, d0 + 16'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 0), (i == 2), (i == 0) ? mk_hdr(6, 3, 16) : {$urandom, $urandom}, (i != 0));
      if (out_vld === 1'b1) nvld++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL af_mid beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (nvld != 3 || out_err !== 1'b0) begin
      failures++; $display("FAIL af_mid_sum beats=%0d err=%b want 3/0", nvld, out_err);
    end
  endtask

  task automatic test_abort();
    logic [15:0] d0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, (i == 0), 1'b0, (i == 0) ? mk_hdr(7, 4, 40) : {$urandom, $urandom}, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL abort_pre beat%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    d0 = drop_cnt;
    step(1'b1, 1'b1, 1'b0, mk_hdr(8, 1, 8), 1'b0);
    checks++;
    if (out_vld !== 1'b1 || out_sop !== 1'b0 || out_eop !== 1'b1 || out_err !== 1'b1 ||
        out_data !== 64'd0 || err_frame !== 1'b1 || drop_cnt !== d0 + 16'd1 || out_des !== 7'd7) begin
      failures++;
      $display("FAIL abort_beat vld=%b sop=%b eop=%b err=%b data=%h frame=%b drop=%0d des=%0d", out_vld, out_sop, out_eop, out_err, out_data, err_frame, drop_cnt, out_des);
    end
    step(1'b1, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
    checks++;
    if (act_vec() !== exp_vec() || out_vld !== 1'b0 || err_frame !== 1'b0) begin
      failures++; $display("FAIL abort_tail act=%h exp=%h", act_vec(), exp_vec());
    end
    step(1'b1, 1'b1, 1'b0, mk_hdr(2, 2, 32), 1'b0);
    step(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 1'b0);
    checks++;
    if (raw_outs() !== 112'd0) begin
      failures++; $display("FAIL mid_reset act=%h exp=0", raw_outs());
    end
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
    checks++;
    if (act_vec() !== exp_vec() || err_frame !== 1'b1 || out_vld !== 1'b0) begin
      failures++; $display("FAIL post_reset act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic        v, s, e, af;
    logic [63:0] d;
    int          len, des;
    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(99, 0) < 80);
      s  = ($urandom_range(99, 0) < (m_in_pkt ? 4 : 40));
      e  = (m_in_pkt && m_left == 1) ? ($urandom_range(99, 0) < 85) : ($urandom_range(99, 0) < 12);
      af = ($urandom_range(99, 0) < 8);
      case ($urandom_range(7, 0))
        0: len = 0;
        1: len = 1024;
        2: len = 1025;
        3: len = 8;
        4: len = 9;
        default: len = $urandom_range(64, 1);
      endcase
      des = ($urandom_range(99, 0) < 85) ? $urandom_range(15, 0) : $urandom_range(127, 16);
      d   = s ? mk_hdr(des, $urandom_range(7, 0), len) : {$urandom, $urandom};
      step(v, s, e, d, af);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 1'b1, 1'b1, mk_hdr(20, 0, 8), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL sat cyc%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (drop_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold drop_cnt=%h want ffff", drop_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = 64'd0; almost_full = 1'b0;
    model_reset();
    test_reset();
    test_legal();
    test_early_eop();
    test_long();
    test_illegal();
    test_almost_full();
    test_abort();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
